alu_ram_seq: RTL and testbench

Parametrised sequential ALU-plus-register-file datapath: the next generation of the team's ALU/RAM pair.
- Accepts commands (opcode, two source addresses, one destination address) over a valid/ready handshake.
- Reads both operands from an internal synchronous dual-read RAM, executes, then writes the result back to the destination address.
- Keeps a persistent carry flag between commands, enabling chained ADC/rotate-through-carry. Also exposes a host load port.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 43 ++++
 rtl/alu_ram_seq.sv | 82 ++++++++
 tb/tb_alu_ram_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and write-enable decode shared by the ALU/RAM datapath
package alu_pkg;
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_NOT = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b0010;
  localparam logic [3:0] OP_SHR = 4'b0011;
  localparam logic [3:0] OP_RCR = 4'b0100;
  localparam logic [3:0] OP_RCL = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_ADD = 4'b1011;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;
  localparam logic [3:0] OP_ADC = 4'b1110;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC} state_t;
  function automatic logic op_writes(input logic [3:0] op);
    return op inside {OP_NOT, OP_SHL, OP_SHR, OP_RCR, OP_RCL, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_ADC};
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, carry/borrow flag and write enable
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int COMAND_WIDTH = 4
) (
  input  logic [COMAND_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic                    i_flag,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic                    o_flag,
  output logic                    o_wr_en
);
  logic [3:0]          w_op;
  logic                w_hi_ok;
  logic [DATA_WIDTH:0] w_t;
  assign w_op    = i_instr[3:0];
  assign w_hi_ok = (i_instr >> 4) == '0;
  // w_t is always {flag, result}, so right shifts place the dropped LSB on top
  always_comb begin
    w_t = '0;
    if (w_hi_ok)
      case (w_op)
        OP_NOT:  w_t = {1'b0, ~i_a};
        OP_SHL:  w_t = {i_a, 1'b0};
        OP_SHR:  w_t = {i_a[0], 1'b0, i_a[DATA_WIDTH-1:1]};
        OP_RCR:  w_t = {i_a[0], i_flag, i_a[DATA_WIDTH-1:1]};
        OP_RCL:  w_t = {i_a, i_flag};
        OP_AND:  w_t = {1'b0, i_a & i_b};
        OP_OR:   w_t = {1'b0, i_a | i_b};
        OP_XOR:  w_t = {1'b0, i_a ^ i_b};
        OP_ADD:  w_t = {1'b0, i_a} + {1'b0, i_b};
        OP_SUB:  w_t = {1'b0, i_a} - {1'b0, i_b};
        OP_ADC:  w_t = {1'b0, i_a} + {1'b0, i_b} + (DATA_WIDTH+1)'(i_flag);
        default: w_t = '0;
      endcase
  end
  assign o_result = w_t[DATA_WIDTH-1:0];
  assign o_flag   = w_t[DATA_WIDTH];
  assign o_wr_en  = w_hi_ok & op_writes(w_op);
endmodule

// File: rtl/alu_ram_seq.sv
// alu_ram_seq: 3-state ALU datapath over a dual-read register file with host load port and persistent carry
module alu_ram_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int COMAND_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [COMAND_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [ADDR_WIDTH-1:0]   addr_d,
  input  logic                    ld_en,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  output logic [DATA_WIDTH-1:0]   res,
  output logic                    flag,
  output logic                    done
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef logic [DATA_WIDTH-1:0] ram_t [DEPTH];
  function automatic ram_t ram_init();
    ram_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_WIDTH'(i + 1);
    return m;
  endfunction
  ram_t                    r_ram = ram_init();
  state_t                  r_state, w_next;
  logic [COMAND_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]   r_addr_a, r_addr_b, r_addr_d;
  logic [DATA_WIDTH-1:0]   r_op_a, r_op_b, w_result;
  logic                    w_flag, w_wr, w_accept;
  assign cmd_ready = r_state == S_IDLE && !ld_en;
  assign w_accept  = cmd_valid && cmd_ready;
  always_comb begin
    w_next = r_state == S_IDLE ? (w_accept ? S_READ : S_IDLE) : r_state == S_READ ? S_EXEC : S_IDLE;
  end
  alu_core #(.DATA_WIDTH(DATA_WIDTH), .COMAND_WIDTH(COMAND_WIDTH)) u_core (
    .i_instr(r_instr), .i_a(r_op_a), .i_b(r_op_b), .i_flag(flag),
    .o_result(w_result), .o_flag(w_flag), .o_wr_en(w_wr)
  );
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      res      <= '0;
      flag     <= 1'b0;
      done     <= 1'b0;
      r_instr  <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_d <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else begin
      r_state <= w_next;
      done    <= r_state == S_EXEC;
      if (w_accept) begin
        r_instr  <= instr;
        r_addr_a <= addr_a;
        r_addr_b <= addr_b;
        r_addr_d <= addr_d;
      end
      if (r_state == S_READ) begin
        r_op_a <= r_ram[r_addr_a];
        r_op_b <= r_ram[r_addr_b];
      end
      if (r_state == S_EXEC) begin
        res  <= w_result;
        flag <= w_flag;
      end
    end
  end
  // Contents survive reset; a reset edge only suppresses writes
  always_ff @(posedge clk) begin
    if (clr && r_state == S_IDLE && ld_en) r_ram[ld_addr] <= ld_data;
    else if (clr && r_state == S_EXEC && w_wr) r_ram[r_addr_d] <= w_result;
  end
endmodule

// File: tb/tb_alu_ram_seq.sv
// tb_alu_ram_seq: directed vectors checked against a cycle-level behavioural model and literal expectations
module tb_alu_ram_seq;
  localparam int M = 16;
  logic       clk = 1'b0;
  logic       clr = 1'b0, cmd_valid = 1'b0, ld_en = 1'b0;
  logic [3:0] instr = '0, addr_a = '0, addr_b = '0, addr_d = '0, ld_addr = '0, ld_data = '0;
  logic       cmd_ready, flag, done;
  logic [3:0] res;
  int n_checks = 0, n_fail = 0;
  int m_ram[M];
  int m_left = 0, m_res = 0, m_flag = 0, m_done = 0, m_op = 0, m_a = 0, m_b = 0, m_d = 0;
  bit m_on = 1'b0;

  alu_ram_seq dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .instr(instr),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .res(res), .flag(flag), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_execute();
    int a, b, r, f;
    bit wr;
    a = m_ram[m_a]; b = m_ram[m_b]; r = 0; f = 0; wr = 1'b1;
    case (m_op)
      1:  r = M - 1 - a;
      2:  begin r = (a * 2) % M; f = a / (M / 2); end
      3:  begin r = a / 2; f = a % 2; end
      4:  begin r = a / 2 + m_flag * (M / 2); f = a % 2; end
      5:  begin r = (a * 2) % M + m_flag; f = a / (M / 2); end
      9:  r = a & b;
      10: r = a | b;
      11: begin r = (a + b) % M; f = (a + b) / M; end
      12: begin r = (a - b + M) % M; f = int'(a < b); end
      13: r = a ^ b;
      14: begin r = (a + b + m_flag) % M; f = (a + b + m_flag) / M; end
      default: wr = 1'b0;
    endcase
    m_res = r; m_flag = f;
    if (wr) m_ram[m_d] = r;
  endfunction

  initial for (int i = 0; i < M; i++) m_ram[i] = (i + 1) % M;

  // Model: a command accepted at one edge completes two edges later
  always @(posedge clk) begin
    if (!clr) begin
      m_left = 0; m_res = 0; m_flag = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_execute(); m_done = 1; end
      end else if (ld_en) m_ram[ld_addr] = int'(ld_data);
      else if (cmd_valid) begin
        m_op = int'(instr); m_a = int'(addr_a); m_b = int'(addr_b); m_d = int'(addr_d); m_left = 2;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (m_on) begin
      check("model_res", int'(res), m_res);
      check("model_flag", int'(flag), m_flag);
      check("model_done", int'(done), m_done);
      check("model_ready", int'(cmd_ready), int'(m_left == 0 && !ld_en));
    end
  end

  task automatic send(input int op, input int a, input int b, input int d);
    int n;
    instr = 4'(op); addr_a = 4'(a); addr_b = 4'(b); addr_d = 4'(d); cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("accept_timeout", int'(n < 20), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    #1;
    check("done_timeout", int'(n < 10), 1);
  endtask

  task automatic host_load(input int addr, input int data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 4'(addr); ld_data = 4'(data);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    int acc;
    @(posedge clk);
    @(negedge clk);
    m_on = 1'b1;
    #1;
    check("rst_res", int'(res), 0);
    check("rst_flag", int'(flag), 0);
    check("rst_done", int'(done), 0);
    clr = 1'b1;
    send(11, 2, 5, 0);
    check("t1_res", int'(res), 9);
    check("t1_flag", int'(flag), 0);
    send(10, 0, 0, 0);
    check("t1_ram0", int'(res), 9);
    host_load(0, 1);
    send(11, 14, 0, 3);
    check("t2_add_res", int'(res), 0);
    check("t2_add_flag", int'(flag), 1);
    send(14, 1, 1, 4);
    check("t2_adc_res", int'(res), 5);
    check("t2_adc_flag", int'(flag), 0);
    send(10, 4, 4, 4);
    check("t2_ram4", int'(res), 5);
    send(12, 0, 1, 5);
    check("t3_sub_res", int'(res), 15);
    check("t3_sub_flag", int'(flag), 1);
    send(4, 2, 0, 6);
    check("t3_rcr_res", int'(res), 9);
    check("t3_rcr_flag", int'(flag), 1);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 4'd12;
    instr = 4'd13; addr_a = 4'd7; addr_b = 4'd7; addr_d = 4'd10; cmd_valid = 1'b1;
    #1;
    check("t4_ready_ld", int'(cmd_ready), 0);
    @(negedge clk);
    ld_en = 1'b0;
    send(13, 7, 7, 10);
    check("t4_xor_res", int'(res), 0);
    send(10, 7, 7, 7);
    check("t4_ram7", int'(res), 12);
    send(2, 14, 0, 11);
    check("t5_pre_flag", int'(flag), 1);
    @(negedge clk);
    instr = 4'd11; addr_a = 4'd14; addr_b = 4'd14; addr_d = 4'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("t5_res", int'(res), 0);
    check("t5_flag", int'(flag), 0);
    check("t5_done", int'(done), 0);
    check("t5_idle", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    send(10, 8, 8, 8);
    check("t5_ram8", int'(res), 9);
    send(2, 14, 0, 11);
    send(7, 3, 3, 9);
    check("t6_undef_res", int'(res), 0);
    check("t6_undef_flag", int'(flag), 0);
    send(0, 3, 3, 9);
    check("t6_nop_flag", int'(flag), 0);
    send(10, 9, 9, 9);
    check("t6_ram9", int'(res), 10);
    @(negedge clk);
    instr = 4'd11; addr_a = 4'd1; addr_b = 4'd1; addr_d = 4'd12; cmd_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("t6_b2b_accepts", acc, 3);
    repeat (3) @(negedge clk);
    #1;
    check("t6_b2b_res", int'(res), 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
